// File: rtl/vram_arbiter_if.sv
// Bundle of the display, writer, clear-engine and RAM-port signals of vram_arbiter.
// The arbiter takes the slave modport; drawing logic, VGA timing and RAM model sit on the master side.
interface vram_arbiter_if #(
    parameter int ADDR_W  = 17,
    parameter int COLOR_W = 3
);
    logic               disp_req;
    logic [8:0]         disp_x;
    logic [7:0]         disp_y;
    logic               disp_valid;
    logic [COLOR_W-1:0] disp_data;

    logic               wr_valid;
    logic [8:0]         wr_x;
    logic [7:0]         wr_y;
    logic [COLOR_W-1:0] wr_data;
    logic               wr_ready;

    logic               clr_start;
    logic [COLOR_W-1:0] clr_color;
    logic               clr_busy;
    logic               clr_done;

    logic               vblank;

    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_we;
    logic [COLOR_W-1:0] mem_wdata;
    logic [COLOR_W-1:0] mem_rdata;

    modport slave (
        input  disp_req, disp_x, disp_y,
        input  wr_valid, wr_x, wr_y, wr_data,
        input  clr_start, clr_color,
        input  vblank,
        input  mem_rdata,
        output disp_valid, disp_data,
        output wr_ready,
        output clr_busy, clr_done,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output disp_req, disp_x, disp_y,
        output wr_valid, wr_x, wr_y, wr_data,
        output clr_start, clr_color,
        output vblank,
        output mem_rdata,
        input  disp_valid, disp_data,
        input  wr_ready,
        input  clr_busy, clr_done,
        input  mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads > clear/fill engine > pixel writer, registered RAM port.
// Optional macro VRAM_VBLANK_WRITE_EN restricts clear and writer traffic to vertical blanking.
module vram_arbiter #(
    parameter int H_RES   = 320,
    parameter int V_RES   = 240,
    parameter int ADDR_W  = 17,
    parameter int COLOR_W = 3
) (
    input  logic           clock,
    input  logic           reset,
    vram_arbiter_if.slave  vram
);
    localparam int                NUM_PIX   = H_RES * V_RES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

    typedef enum logic {
        S_IDLE,
        S_FILL
    } clrState_t;

    // 320 = 256 + 64, so the common geometry needs only two shifts and an add.
    function automatic logic [ADDR_W-1:0] pixAddr(input logic [8:0] x, input logic [7:0] y);
        if (H_RES == 320)
            return (ADDR_W'(y) << 8) + (ADDR_W'(y) << 6) + ADDR_W'(x);
        else
            return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
    endfunction

    clrState_t          r_state;
    clrState_t          w_nextState;
    logic [ADDR_W-1:0]  r_count;
    logic [ADDR_W-1:0]  w_nextCount;
    logic [COLOR_W-1:0] r_color;
    logic [COLOR_W-1:0] w_nextColor;
    logic               r_clrDone;
    logic               w_clrDone;

    logic [ADDR_W-1:0]  r_memAddr;
    logic               r_memWe;
    logic [COLOR_W-1:0] r_memWdata;
    logic [ADDR_W-1:0]  w_nextAddr;
    logic               w_nextWe;
    logic [COLOR_W-1:0] w_nextWdata;

    logic               r_dispPend;
    logic               r_dispPendHit;
    logic               r_dispValid;
    logic               r_dispHit;

    logic [ADDR_W-1:0]  w_dispAddr;
    logic [ADDR_W-1:0]  w_wrAddr;
    logic               w_dispInRange;
    logic               w_wrInRange;
    logic               w_portOk;
    logic               w_clrBusy;
    logic               w_wrReady;
    logic               w_wrAccept;
    logic               w_fillGo;

`ifdef VRAM_VBLANK_WRITE_EN
    assign w_portOk = vram.vblank;
`else
    logic w_unusedVblank;
    assign w_unusedVblank = vram.vblank;
    assign w_portOk       = 1'b1;
`endif

    assign w_dispAddr    = pixAddr(vram.disp_x, vram.disp_y);
    assign w_wrAddr      = pixAddr(vram.wr_x, vram.wr_y);
    assign w_dispInRange = (32'(vram.disp_x) < H_RES) && (32'(vram.disp_y) < V_RES);
    assign w_wrInRange   = (32'(vram.wr_x) < H_RES) && (32'(vram.wr_y) < V_RES);

    assign w_clrBusy  = (r_state == S_FILL);
    assign w_wrReady  = ~vram.disp_req & ~w_clrBusy & w_portOk;
    assign w_wrAccept = vram.wr_valid & w_wrReady;
    assign w_fillGo   = w_clrBusy & ~vram.disp_req & w_portOk;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_color   <= '0;
            r_clrDone <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_count   <= w_nextCount;
            r_color   <= w_nextColor;
            r_clrDone <= w_clrDone;
        end
    end

    // The counter only advances on cycles where the fill actually owns the port.
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_nextColor = r_color;
        w_clrDone   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (vram.clr_start) begin
                    w_nextState = S_FILL;
                    w_nextCount = '0;
                    w_nextColor = vram.clr_color;
                end
            end
            S_FILL: begin
                if (w_fillGo) begin
                    if (r_count == LAST_ADDR) begin
                        w_nextState = S_IDLE;
                        w_nextCount = '0;
                        w_clrDone   = 1'b1;
                    end else begin
                        w_nextCount = r_count + ADDR_W'(1);
                    end
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Port owner for the next cycle; an out-of-range owner still holds the port but touches nothing.
    always_comb begin
        w_nextAddr  = r_memAddr;
        w_nextWe    = 1'b0;
        w_nextWdata = r_memWdata;
        if (vram.disp_req) begin
            if (w_dispInRange)
                w_nextAddr = w_dispAddr;
        end else if (w_fillGo) begin
            w_nextAddr  = r_count;
            w_nextWe    = 1'b1;
            w_nextWdata = r_color;
        end else if (w_wrAccept && w_wrInRange) begin
            w_nextAddr  = w_wrAddr;
            w_nextWe    = 1'b1;
            w_nextWdata = vram.wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_memAddr     <= '0;
            r_memWe       <= 1'b0;
            r_memWdata    <= '0;
            r_dispPend    <= 1'b0;
            r_dispPendHit <= 1'b0;
            r_dispValid   <= 1'b0;
            r_dispHit     <= 1'b0;
        end else begin
            r_memAddr     <= w_nextAddr;
            r_memWe       <= w_nextWe;
            r_memWdata    <= w_nextWdata;
            r_dispPend    <= vram.disp_req;
            r_dispPendHit <= vram.disp_req & w_dispInRange;
            r_dispValid   <= r_dispPend;
            r_dispHit     <= r_dispPendHit;
        end
    end

    assign vram.mem_addr   = r_memAddr;
    assign vram.mem_we     = r_memWe;
    assign vram.mem_wdata  = r_memWdata;
    assign vram.disp_valid = r_dispValid;
    assign vram.disp_data  = (r_dispValid && r_dispHit) ? vram.mem_rdata : '0;
    assign vram.wr_ready   = w_wrReady;
    assign vram.clr_busy   = w_clrBusy;
    assign vram.clr_done   = r_clrDone;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: full-size instance for addressing/handshake vectors, short-screen instance
// (320x16) for the clear engine so full fills stay short; honours VRAM_VBLANK_WRITE_EN.
module tb_vram_arbiter;
    localparam int PIX_A = 76800;
    localparam int PIX_B = 5120;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    vram_arbiter_if #(.ADDR_W(17), .COLOR_W(3)) busA ();
    vram_arbiter_if #(.ADDR_W(17), .COLOR_W(3)) busB ();

    vram_arbiter #(.H_RES(320), .V_RES(240), .ADDR_W(17), .COLOR_W(3)) dutA (
        .clock(clock), .reset(reset), .vram(busA.slave)
    );
    vram_arbiter #(.H_RES(320), .V_RES(16), .ADDR_W(17), .COLOR_W(3)) dutB (
        .clock(clock), .reset(reset), .vram(busB.slave)
    );

    logic [2:0] ramA [0:PIX_A-1];
    logic [2:0] ramB [0:PIX_B-1];

    // Synchronous RAM models: one-cycle read latency, write on mem_we.
    always @(posedge clock) begin
        if (32'(busA.mem_addr) < PIX_A) begin
            if (busA.mem_we) ramA[busA.mem_addr] <= busA.mem_wdata;
            busA.mem_rdata <= ramA[busA.mem_addr];
        end else begin
            busA.mem_rdata <= 3'd0;
        end
        if (32'(busB.mem_addr) < PIX_B) begin
            if (busB.mem_we) ramB[busB.mem_addr[12:0]] <= busB.mem_wdata;
            busB.mem_rdata <= ramB[busB.mem_addr[12:0]];
        end else begin
            busB.mem_rdata <= 3'd0;
        end
    end

    typedef struct {
        int dispReq; int dx; int dy;
        int wrValid; int wx; int wy; int wd;
        int expReady; int expWe; int expAddr; int expWdata; int expDv; int expDd;
    } vec_t;

    vec_t vecs [18];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        busA.disp_req = v.dispReq[0];
        busA.disp_x   = 9'(v.dx);
        busA.disp_y   = 8'(v.dy);
        busA.wr_valid = v.wrValid[0];
        busA.wr_x     = 9'(v.wx);
        busA.wr_y     = 8'(v.wy);
        busA.wr_data  = 3'(v.wd);
    endtask

    initial begin
        int busyCnt;
        int fillWrites;
        int badWrites;
        int doneCnt;
        int nextAddr;
        int writes;

        for (int i = 0; i < PIX_A; i++) ramA[i] = 3'd0;
        for (int i = 0; i < PIX_B; i++) ramB[i] = 3'd0;
        ramA[0]       = 3'd5;
        ramA[PIX_A-1] = 3'd3;

        //          req  dx  dy  wv  wx wy wd  rdy we addr  wd dv dd
        vecs[0]  = '{1,   0,  0, 0,   0, 0, 0,  0, 0,    0, 0, 0, 0};
        vecs[1]  = '{1, 319,239, 0,   0, 0, 0,  0, 0,    0, 0, 0, 0};
        vecs[2]  = '{0,   0,  0, 0,   0, 0, 0,  1, 0,76799, 0, 1, 5};
        vecs[3]  = '{0,   0,  0, 1,  10, 2, 6,  1, 0,76799, 0, 1, 3};
        vecs[4]  = '{0,   0,  0, 0,   0, 0, 0,  1, 1,  650, 6, 0, 0};
        vecs[5]  = '{1,   5,  0, 1,  10, 3, 2,  0, 0,  650, 6, 0, 0};
        vecs[6]  = '{0,   0,  0, 1,  10, 3, 2,  1, 0,    5, 6, 0, 0};
        vecs[7]  = '{0,   0,  0, 0,   0, 0, 0,  1, 1,  970, 2, 1, 0};
        vecs[8]  = '{0,   0,  0, 1, 320, 5, 7,  1, 0,  970, 2, 0, 0};
        vecs[9]  = '{1,   0,240, 0,   0, 0, 0,  0, 0,  970, 2, 0, 0};
        vecs[10] = '{0,   0,  0, 0,   0, 0, 0,  1, 0,  970, 2, 0, 0};
        vecs[11] = '{0,   0,  0, 0,   0, 0, 0,  1, 0,  970, 2, 1, 0};
        vecs[12] = '{1,  10,  2, 0,   0, 0, 0,  0, 0,  970, 2, 0, 0};
        vecs[13] = '{0,   0,  0, 0,   0, 0, 0,  1, 0,  650, 2, 0, 0};
        vecs[14] = '{0,   0,  0, 0,   0, 0, 0,  1, 0,  650, 2, 1, 6};
        vecs[15] = '{1,   0,  6, 0,   0, 0, 0,  0, 0,  650, 2, 0, 0};
        vecs[16] = '{0,   0,  0, 0,   0, 0, 0,  1, 0, 1920, 2, 0, 0};
        vecs[17] = '{0,   0,  0, 0,   0, 0, 0,  1, 0, 1920, 2, 1, 0};

        reset = 1'b1;
        busA.disp_req = 0; busA.disp_x = 0; busA.disp_y = 0;
        busA.wr_valid = 0; busA.wr_x = 0; busA.wr_y = 0; busA.wr_data = 0;
        busA.clr_start = 0; busA.clr_color = 0; busA.vblank = 1;
        busB.disp_req = 0; busB.disp_x = 0; busB.disp_y = 0;
        busB.wr_valid = 0; busB.wr_x = 0; busB.wr_y = 0; busB.wr_data = 0;
        busB.clr_start = 0; busB.clr_color = 0; busB.vblank = 1;

        step();
        step();
        checkOutput("rst.mem_we",     busA.mem_we,     0);
        checkOutput("rst.mem_addr",   busA.mem_addr,   0);
        checkOutput("rst.mem_wdata",  busA.mem_wdata,  0);
        checkOutput("rst.disp_valid", busA.disp_valid, 0);
        checkOutput("rst.disp_data",  busA.disp_data,  0);
        checkOutput("rst.clr_busy",   busA.clr_busy,   0);
        checkOutput("rst.clr_done",   busA.clr_done,   0);
        checkOutput("rst.wr_ready",   busA.wr_ready,   1);
        reset = 1'b0;
        step();

        for (int i = 0; i < 18; i++) begin
            step();
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d.wr_ready", i),   busA.wr_ready,   vecs[i].expReady);
            checkOutput($sformatf("v%0d.mem_we", i),     busA.mem_we,     vecs[i].expWe);
            checkOutput($sformatf("v%0d.mem_addr", i),   busA.mem_addr,   vecs[i].expAddr);
            checkOutput($sformatf("v%0d.mem_wdata", i),  busA.mem_wdata,  vecs[i].expWdata);
            checkOutput($sformatf("v%0d.disp_valid", i), busA.disp_valid, vecs[i].expDv);
            checkOutput($sformatf("v%0d.disp_data", i),  busA.disp_data,  vecs[i].expDd);
        end
        busA.disp_req = 0;
        busA.wr_valid = 0;

        // Writer gating by vertical blanking
`ifdef VRAM_VBLANK_WRITE_EN
        step();
        busA.vblank = 0; busA.wr_valid = 1; busA.wr_x = 1; busA.wr_y = 1; busA.wr_data = 3;
        #1;
        checkOutput("vb.ready_low", busA.wr_ready, 0);
        step();
        checkOutput("vb.no_write", busA.mem_we, 0);
        busA.vblank = 1;
        #1;
        checkOutput("vb.ready_high", busA.wr_ready, 1);
        step();
        busA.wr_valid = 0;
        checkOutput("vb.mem_we",    busA.mem_we,    1);
        checkOutput("vb.mem_addr",  busA.mem_addr,  321);
        checkOutput("vb.mem_wdata", busA.mem_wdata, 3);
`else
        step();
        busA.vblank = 0; busA.wr_valid = 1; busA.wr_x = 1; busA.wr_y = 1; busA.wr_data = 3;
        #1;
        checkOutput("vb.ready_ignored", busA.wr_ready, 1);
        step();
        busA.wr_valid = 0; busA.vblank = 1;
        checkOutput("vb.mem_we",    busA.mem_we,    1);
        checkOutput("vb.mem_addr",  busA.mem_addr,  321);
        checkOutput("vb.mem_wdata", busA.mem_wdata, 3);
`endif

        // Full clear with a simultaneous write in the start cycle
        step();
        busB.clr_start = 1; busB.clr_color = 4;
        busB.wr_valid = 1; busB.wr_x = 1; busB.wr_y = 0; busB.wr_data = 1;
        #1;
        checkOutput("clr.start_wr_ready", busB.wr_ready, 1);
        step();
        busB.clr_start = 0; busB.wr_valid = 0;
        #1;
        checkOutput("clr.wr_ready_busy", busB.wr_ready, 0);
        checkOutput("clr.busy_rise", busB.clr_busy, 1);
        checkOutput("clr.wr_we",    busB.mem_we,    1);
        checkOutput("clr.wr_addr",  busB.mem_addr,  1);
        checkOutput("clr.wr_wdata", busB.mem_wdata, 1);
        busyCnt = 1; fillWrites = 0; badWrites = 0; doneCnt = 0; nextAddr = 0;
        for (int c = 0; c < 20000 && doneCnt == 0; c++) begin
            step();
            if (busB.clr_busy) busyCnt++;
            if (busB.mem_we) begin
                if (busB.mem_wdata == 3'd4 && 32'(busB.mem_addr) == nextAddr) begin
                    nextAddr++;
                    fillWrites++;
                end else begin
                    badWrites++;
                end
            end
            if (busB.clr_done) doneCnt++;
        end
        checkOutput("clr.fill_writes", fillWrites, PIX_B);
        checkOutput("clr.bad_writes",  badWrites,  0);
        checkOutput("clr.busy_cycles", busyCnt,    PIX_B);
        checkOutput("clr.done_seen",   doneCnt,    1);
        checkOutput("clr.busy_end",    busB.clr_busy, 0);
        step();
        checkOutput("clr.done_pulse",  busB.clr_done, 0);
        checkOutput("clr.idle_we",     busB.mem_we,   0);
        checkOutput("clr.ram_first",   ramB[0],       4);
        checkOutput("clr.ram_wrpix",   ramB[1],       4);
        checkOutput("clr.ram_last",    ramB[PIX_B-1], 4);

        // Fill with display requests every other cycle
        busB.clr_start = 1; busB.clr_color = 2;
        step();
        busB.clr_start = 0;
        busyCnt = 0;
        for (int c = 0; c < 30000; c++) begin
            busB.disp_req = (c % 2 == 0);
            #1;
            if (!busB.clr_busy) break;
            busyCnt++;
            step();
        end
        checkOutput("alt.busy_cycles", busyCnt, 2 * PIX_B);
        checkOutput("alt.done",        busB.clr_done, 1);
        busB.disp_req = 0;
        step();
        checkOutput("alt.ram_last", ramB[PIX_B-1], 2);

        // Reset in the middle of a fill, with a display read in flight
        busB.clr_start = 1; busB.clr_color = 6;
        step();
        busB.clr_start = 0;
        writes = 0;
        for (int c = 0; c < 5000 && writes < 1000; c++) begin
            step();
            if (busB.mem_we) writes++;
        end
        checkOutput("rmid.writes", writes, 1000);
        busB.disp_req = 1; busB.disp_x = 0; busB.disp_y = 0;
        step();
        busB.disp_req = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("rmid.clr_busy",   busB.clr_busy,   0);
        checkOutput("rmid.mem_we",     busB.mem_we,     0);
        checkOutput("rmid.clr_done",   busB.clr_done,   0);
        checkOutput("rmid.mem_addr",   busB.mem_addr,   0);
        checkOutput("rmid.disp_valid", busB.disp_valid, 0);
        step();
        checkOutput("rmid.disp_valid2", busB.disp_valid, 0);
        checkOutput("rmid.clr_done2",   busB.clr_done,   0);
        busB.clr_start = 1; busB.clr_color = 5;
        step();
        busB.clr_start = 0;
        checkOutput("restart.busy", busB.clr_busy, 1);
        step();
        checkOutput("restart.we",    busB.mem_we,    1);
        checkOutput("restart.addr",  busB.mem_addr,  0);
        checkOutput("restart.wdata", busB.mem_wdata, 5);
        busB.clr_start = 1; busB.clr_color = 7;
        step();
        busB.clr_start = 0;
        checkOutput("restart.addr1",  busB.mem_addr,  1);
        checkOutput("restart.wdata1", busB.mem_wdata, 5);
        step();
        checkOutput("ignore.addr2",  busB.mem_addr,  2);
        checkOutput("ignore.wdata2", busB.mem_wdata, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
